// File: rtl/game_pkg.sv
// Shared types, widths and BCD/clamp helpers for the game countdown timer.
package game_pkg;

  localparam int unsigned COUNT_W     = 7;
  localparam int unsigned BCD_W       = 4;
  localparam int unsigned MAX_SECONDS = 99;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } timer_state_t;

  function automatic logic [COUNT_W-1:0] clamp_load(input logic [COUNT_W-1:0] v,
                                                    input logic [COUNT_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_tens_of(input logic [COUNT_W-1:0] v);
    return BCD_W'(v / COUNT_W'(10));
  endfunction

  function automatic logic [BCD_W-1:0] bcd_units_of(input logic [COUNT_W-1:0] v);
    return BCD_W'(v % COUNT_W'(10));
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a registered
// single-cycle rising-edge pulse.
module edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise_q;

  // s1/s2 resolve metastability; s3 holds the previous synchronized level.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/game_timer.sv
// Seconds countdown driven by synchronized slow_clk rising edges, with
// start/pause/expiry control and BCD digits. Define GAME_TIMER_AUTO_RELOAD_EN
// to reload the latched start value on expiry instead of stopping.
module game_timer #(
  parameter int unsigned MAX_COUNT      = 99,
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] load_val,
  output logic [6:0] count,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       running,
  output logic       expired,
  output logic       tick
);

  import game_pkg::*;

  localparam int unsigned PRESC_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_STEP - 1);
  localparam logic [COUNT_W-1:0] LOAD_MAX =
    COUNT_W'((MAX_COUNT > MAX_SECONDS) ? MAX_SECONDS : MAX_COUNT);

  timer_state_t       state_q;
  logic [COUNT_W-1:0] count_q;
  logic [PRESC_W-1:0] presc_q;
  logic               running_q;
  logic               expired_q;
  logic               tick_w;
  logic [COUNT_W-1:0] load_clamped;
  logic               step_due;
`ifdef GAME_TIMER_AUTO_RELOAD_EN
  logic [COUNT_W-1:0] reload_q;
`endif

  edge_sync u_slow_sync (
    .clk_in     (clk_in),
    .rst        (rst),
    .async_in   (slow_clk),
    .rise_pulse (tick_w)
  );

  assign load_clamped = clamp_load(load_val, LOAD_MAX);
  assign step_due     = (presc_q == PRESC_LAST);

  // Priority: rst > start > pause > tick; a tick coincident with start is dropped.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
`ifdef GAME_TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      expired_q <= 1'b0;
      if (start) begin
        presc_q <= '0;
`ifdef GAME_TIMER_AUTO_RELOAD_EN
        reload_q <= load_clamped;
`endif
        if (load_clamped == '0) begin
          state_q   <= DONE;
          count_q   <= '0;
          running_q <= 1'b0;
          expired_q <= 1'b1;
        end else begin
          state_q   <= RUN;
          count_q   <= load_clamped;
          running_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (pause) begin
              state_q   <= PAUSED;
              running_q <= 1'b0;
            end else if (tick_w) begin
              if (step_due) begin
                presc_q <= '0;
                if (count_q == COUNT_W'(1)) begin
                  expired_q <= 1'b1;
`ifdef GAME_TIMER_AUTO_RELOAD_EN
                  if (reload_q != '0) begin
                    count_q <= reload_q;
                  end else begin
                    count_q   <= '0;
                    state_q   <= DONE;
                    running_q <= 1'b0;
                  end
`else
                  count_q   <= '0;
                  state_q   <= DONE;
                  running_q <= 1'b0;
`endif
                end else begin
                  count_q <= count_q - COUNT_W'(1);
                end
              end else begin
                presc_q <= presc_q + PRESC_W'(1);
              end
            end
          end
          PAUSED: begin
            if (!pause) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count     = count_q;
  assign bcd_tens  = bcd_tens_of(count_q);
  assign bcd_units = bcd_units_of(count_q);
  assign running   = running_q;
  assign expired   = expired_q;
  assign tick      = tick_w;

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer: one instance steps every rise,
// a second steps every two rises; both share the same stimulus.
module tb_game_timer;

`ifdef GAME_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       slow_clk;
  logic       start;
  logic       pause;
  logic [6:0] load_val;

  logic [6:0] count,  count2;
  logic [3:0] tens,   tens2;
  logic [3:0] units,  units2;
  logic       running, running2;
  logic       expired, expired2;
  logic       tick,   tick2;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int exp2_cnt = 0;
  int tick_cnt = 0;
  int tick2_cnt = 0;
  int exp_n4   = 0;
  int cnt_n4   = 0;

  game_timer #(.MAX_COUNT(99), .TICKS_PER_STEP(1)) dut (
    .clk_in(clk), .rst(rst), .slow_clk(slow_clk), .start(start), .pause(pause),
    .load_val(load_val), .count(count), .bcd_tens(tens), .bcd_units(units),
    .running(running), .expired(expired), .tick(tick)
  );

  game_timer #(.MAX_COUNT(99), .TICKS_PER_STEP(2)) dut2 (
    .clk_in(clk), .rst(rst), .slow_clk(slow_clk), .start(start), .pause(pause),
    .load_val(load_val), .count(count2), .bcd_tens(tens2), .bcd_units(units2),
    .running(running2), .expired(expired2), .tick(tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (expired)  exp_cnt++;
    if (expired2) exp2_cnt++;
    if (tick)     tick_cnt++;
    if (tick2)    tick2_cnt++;
  end

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic do_start(input int v);
    load_val = 7'(v);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // One clean slow_clk rise: tick appears after the 3rd edge, count moves on the 4th.
  task automatic rise();
    slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    check("tick_early", tick, 0);
    @(negedge clk);
    check("tick_hi", tick, 1);
    slow_clk = 1'b0;
    @(negedge clk);
    check("tick_lo", tick, 0);
    exp_n4 = expired;
    cnt_n4 = count;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e0;
    int t0;
    int t20;
    rst = 1'b1; slow_clk = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_count",   count,   0);
    check("rst_tens",    tens,    0);
    check("rst_units",   units,   0);
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    check("rst_tick",    tick,    0);
    check("rst_tens2",   tens2,   0);
    check("rst_units2",  units2,  0);

    // Load 5 and count down to expiry.
    e0 = exp_cnt;
    do_start(5);
    check("t2_load",    count,   5);
    check("t2_run",     running, 1);
    check("t2_units",   units,   5);
    check("t2_tens",    tens,    0);
    check("t2_load2",   count2,  5);
    for (int i = 1; i <= 5; i++) begin
      rise();
      check("t2_count", count, (AUTO && i == 5) ? 5 : 5 - i);
      check("t2_units", units, (AUTO && i == 5) ? 5 : 5 - i);
    end
    check("t2_exp_n4",   exp_n4, 1);
    check("t2_cnt_n4",   cnt_n4, AUTO ? 5 : 0);
    check("t2_exp_once", exp_cnt - e0, 1);
    check("t2_running",  running, AUTO ? 1 : 0);
    rise();
    check("t2_hold",     count, AUTO ? 4 : 0);
    check("t2_exp_tot",  exp_cnt - e0, 1);
    check("t2_dut2",     count2, 2);

    // Clamp and zero load.
    do_start(120);
    check("t3_clamp",  count, 99);
    check("t3_tens",   tens,  9);
    check("t3_units",  units, 9);
    check("t3_tens2",  tens2, 9);
    check("t3_units2", units2, 9);
    do_start(0);
    check("t3_zero",     count,   0);
    check("t3_zero_exp", expired, 1);
    check("t3_zero_run", running, 0);
    @(negedge clk);
    check("t3_exp_1cyc", expired, 0);

    // Pause across three rises.
    do_start(10);
    pause = 1'b1;
    @(negedge clk);
    check("t4_paused", running, 0);
    repeat (3) rise();
    check("t4_hold",  count,  10);
    check("t4_hold2", count2, 10);
    pause = 1'b0;
    @(negedge clk);
    check("t4_resume", running, 1);
    rise();
    check("t4_step",  count,  9);
    check("t4_presc2", count2, 10);
    rise();
    check("t4_step2", count2, 9);

    // Two ticks per step, with a paused rise in the middle.
    do_start(3);
    rise();
    check("t5_r1", count2, 3);
    pause = 1'b1;
    @(negedge clk);
    rise();
    check("t5_r2_paused", count2, 3);
    pause = 1'b0;
    @(negedge clk);
    rise();
    check("t5_r3", count2, 2);
    e0 = exp2_cnt;
    repeat (3) rise();
    check("t5_r6", count2, 1);
    rise();
    check("t5_r7",     count2,   AUTO ? 3 : 0);
    check("t5_run2",   running2, AUTO ? 1 : 0);
    check("t5_exp2",   exp2_cnt - e0, 1);

    // Start coincident with a tick drops the tick and clears the prescaler.
    do_start(8);
    rise();
    check("t6_pre", count, 7);
    check("t6_pre2", count2, 8);
    slow_clk = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_tick", tick, 1);
    load_val = 7'd20;
    start    = 1'b1;
    slow_clk = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("t6_load",  count,   20);
    check("t6_load2", count2,  20);
    check("t6_run",   running, 1);
    repeat (4) @(negedge clk);
    check("t6_no_dec", count, 20);
    rise();
    check("t6_next",  count,  19);
    check("t6_next2", count2, 20);

    // Reset mid-count, and reset swallowing a pending final tick.
    do_start(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_count", count,   0);
    check("t7_tens",  tens,    0);
    check("t7_units", units,   0);
    check("t7_run",   running, 0);
    check("t7_exp",   expired, 0);
    check("t7_count2", count2, 0);
    do_start(1);
    e0 = exp_cnt;
    slow_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    slow_clk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t7b_count", count,   0);
    check("t7b_exp",   expired, 0);
    check("t7b_tick",  tick,    0);
    check("t7b_run",   running, 0);
    repeat (3) @(negedge clk);
    check("t7b_no_exp", exp_cnt - e0, 0);
    rise();
    check("t7_idle_ignore", count, 0);

    // Static slow_clk, then asynchronous rises.
    do_start(9);
    t0  = tick_cnt;
    t20 = tick2_cnt;
    repeat (20) @(negedge clk);
    check("t8_frozen",  count, 9);
    check("t8_no_tick", tick_cnt - t0, 0);
    for (int k = 0; k < 4; k++) begin
      #3  slow_clk = 1'b1;
      #37 slow_clk = 1'b0;
      #41;
    end
    @(negedge clk);
    check("t9_ticks",  tick_cnt - t0, 4);
    check("t9_ticks2", tick2_cnt - t20, 4);
    check("t9_count",  count, 5);
    check("t9_count2", count2, 7);

    // Expiry behaviour for a short reload value.
    do_start(2);
    e0 = exp_cnt;
    repeat (6) rise();
    check("t10_exp",   exp_cnt - e0, AUTO ? 3 : 1);
    check("t10_run",   running,      AUTO ? 1 : 0);
    check("t10_count", count,        AUTO ? 2 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
